// File: rtl/modulo_escalonador_rolhas_pkg.sv
// Shared definitions for the cork-buffer scheduler: state codes, count widths
// and default buffer limits.
package pkg_rolhas;

   localparam int PRI_W = 5;
   localparam int SEC_W = 7;

   localparam int SEC_MAX_DEF  = 99;
   localparam int PRI_MIN_DEF  = 5;
   localparam int XFER_QTY_DEF = 20;

   // Code 2'b11 is deliberately left out; the FSM folds it back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_TRANSFER = 2'b01,
      ST_LOAD     = 2'b10
   } estado_t;

endpackage

// File: rtl/modulo_escalonador_rolhas_borda.sv
// Registered rising-edge detector for the operator load button.
module modulo_detector_borda_op (
   input  logic clk,
   input  logic clr,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) din_q <= 1'b0;
      else      din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/modulo_escalonador_rolhas.sv
// Cork-buffer scheduler: owns principal/secondary counts and serialises
// automatic secondary->principal transfers with operator reloads.
module modulo_escalonador_rolhas
   import pkg_rolhas::*;
#(
   parameter int SEC_MAX  = SEC_MAX_DEF,
   parameter int PRI_MIN  = PRI_MIN_DEF,
   parameter int XFER_QTY = XFER_QTY_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             enable,
   input  logic             seal_pulse,
   input  logic             op_req,
   input  logic [SEC_W-1:0] op_qty,
   output logic [PRI_W-1:0] pri_count,
   output logic [SEC_W-1:0] sec_count,
   output logic [1:0]       estado,
   output logic             xfer_busy,
   output logic             load_busy,
   output logic             op_reject,
   output logic             ro
);

   localparam int XFER_W = $clog2(XFER_QTY + 1);

   estado_t              state_q, state_d;
   logic                 load_pend_q;
   logic [SEC_W-1:0]     load_rem_q;
   logic [XFER_W-1:0]    xfer_rem_q;
   logic [PRI_W-1:0]     pri_d;
   logic [SEC_W-1:0]     sec_d;
   logic                 op_rise;
   logic [SEC_W:0]       load_sum;
   logic                 req_busy, req_accept, req_refuse;
   logic                 xfer_cond, start_xfer, start_load;
   logic                 xfer_move, load_move;

   modulo_detector_borda_op u_borda (
      .clk  (clk),
      .clr  (clr),
      .din  (op_req),
      .rise (op_rise)
   );

   // Sum kept one bit wider so 99 + 127 cannot wrap into an accept.
   assign load_sum   = {1'b0, sec_count} + {1'b0, op_qty};
   assign req_busy   = load_pend_q || (state_q == ST_LOAD);
   assign req_refuse = op_rise && (req_busy || (load_sum > (SEC_W+1)'(SEC_MAX)));
   assign req_accept = op_rise && !req_busy && (load_sum <= (SEC_W+1)'(SEC_MAX))
                       && (op_qty != '0);

   assign xfer_cond = (pri_count < PRI_W'(PRI_MIN)) && (sec_count >= SEC_W'(XFER_QTY));
   assign xfer_move = (state_q == ST_TRANSFER);
   assign load_move = (state_q == ST_LOAD);

   always_comb begin
      state_d    = state_q;
      start_xfer = 1'b0;
      start_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               if (xfer_cond) begin
                  state_d    = ST_TRANSFER;
                  start_xfer = 1'b1;
               end else if (load_pend_q) begin
                  state_d    = ST_LOAD;
                  start_load = 1'b1;
               end
            end
         end
         ST_TRANSFER: if (xfer_rem_q <= XFER_W'(1)) state_d = ST_IDLE;
         ST_LOAD:     if (load_rem_q <= SEC_W'(1))  state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Single resolution point for the principal count: a seal landing on a
   // transfer cycle cancels that cycle's increment.
   always_comb begin
      pri_d = pri_count;
      if (xfer_move && !seal_pulse)
         pri_d = pri_count + PRI_W'(1);
      else if (!xfer_move && seal_pulse && (pri_count != '0))
         pri_d = pri_count - PRI_W'(1);
   end

   always_comb begin
      sec_d = sec_count;
      if (xfer_move)      sec_d = sec_count - SEC_W'(1);
      else if (load_move) sec_d = sec_count + SEC_W'(1);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= ST_IDLE;
         pri_count <= '0;
         sec_count <= '0;
         op_reject <= 1'b0;
      end else begin
         state_q   <= state_d;
         pri_count <= pri_d;
         sec_count <= sec_d;
         op_reject <= req_refuse;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         xfer_rem_q <= '0;
      end else if (start_xfer) begin
         xfer_rem_q <= XFER_W'(XFER_QTY);
      end else if (xfer_move) begin
         xfer_rem_q <= xfer_rem_q - XFER_W'(1);
      end
   end

   // Accept and start are mutually exclusive: accept needs no pending load.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         load_pend_q <= 1'b0;
         load_rem_q  <= '0;
      end else if (req_accept) begin
         load_pend_q <= 1'b1;
         load_rem_q  <= op_qty;
      end else begin
         if (start_load) load_pend_q <= 1'b0;
         if (load_move)  load_rem_q  <= load_rem_q - SEC_W'(1);
      end
   end

   assign estado    = state_q;
   assign xfer_busy = xfer_move;
   assign load_busy = load_move;
   assign ro        = (pri_count == '0);

endmodule

// File: tb/tb_modulo_escalonador_rolhas.sv
// Self-checking bench for the cork-buffer scheduler: vector table of operator
// loads plus hand-built sequences for priority, seal-in-transfer and clear.
module tb_modulo_escalonador_rolhas;

   logic       clk = 1'b0;
   logic       clr;
   logic       enable;
   logic       seal_pulse;
   logic       op_req;
   logic [6:0] op_qty;
   logic [4:0] pri_count;
   logic [6:0] sec_count;
   logic [1:0] estado;
   logic       xfer_busy, load_busy, op_reject, ro;

   int checks   = 0;
   int failures = 0;

   modulo_escalonador_rolhas dut (
      .clk        (clk),
      .clr        (clr),
      .enable     (enable),
      .seal_pulse (seal_pulse),
      .op_req     (op_req),
      .op_qty     (op_qty),
      .pri_count  (pri_count),
      .sec_count  (sec_count),
      .estado     (estado),
      .xfer_busy  (xfer_busy),
      .load_busy  (load_busy),
      .op_reject  (op_reject),
      .ro         (ro)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_load;
      int cycles;
      int pri;
      int sec;
   } exp_op_t;

   typedef struct {
      int qty;
      bit rej;
      bit do_load;
      bit do_xfer;
      int pri;
      int sec;
   } vec_t;

   exp_op_t sb[$];
   vec_t    tbl[6];
   int      m_pri, m_sec;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic seal_n(input int n);
      seal_pulse = 1'b1;
      repeat (n) tick();
      seal_pulse = 1'b0;
   endtask

   task automatic pulse_req(input int q);
      op_qty = 7'(q);
      op_req = 1'b1;
      tick();
      op_req = 1'b0;
   endtask

   // Runs until the scoreboard drains and the FSM has sat idle; each completed
   // operation pops one expectation and is compared on its IDLE return.
   task automatic run_ops(input int budget);
      int      busy_cnt  = 0;
      int      idle_cnt  = 0;
      int      gap       = -1;
      bit      prev_busy = 1'b0;
      bit      cur_load  = 1'b0;
      exp_op_t e;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (xfer_busy || load_busy) begin
            if (!prev_busy) begin
               if (gap >= 0) chk("idle_gap", gap, 1);
               busy_cnt = 0;
               cur_load = load_busy;
            end else if (load_busy != cur_load) begin
               chk("op_switch_no_idle", int'(load_busy), int'(cur_load));
            end
            busy_cnt++;
            idle_cnt  = 0;
            prev_busy = 1'b1;
         end else begin
            if (prev_busy) begin
               if (sb.size() == 0) begin
                  chk("unexpected_op", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("op_kind", int'(cur_load), int'(e.is_load));
                  chk("op_cycles", busy_cnt, e.cycles);
                  chk("op_pri", int'(pri_count), e.pri);
                  chk("op_sec", int'(sec_count), e.sec);
               end
               gap = 1;
            end else if (gap >= 0) begin
               gap++;
            end
            prev_busy = 1'b0;
            idle_cnt++;
            if (sb.size() == 0 && idle_cnt >= 4) return;
         end
      end
      chk("sb_timeout", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int n;

      // qty, reject, load, transfer-follows, final pri, final sec
      tbl[0] = '{40, 1'b0, 1'b1, 1'b1, 20, 20};
      tbl[1] = '{ 0, 1'b0, 1'b0, 1'b0, 20, 20};
      tbl[2] = '{70, 1'b0, 1'b1, 1'b0, 20, 90};
      tbl[3] = '{10, 1'b1, 1'b0, 1'b0, 20, 90};
      tbl[4] = '{ 9, 1'b0, 1'b1, 1'b0, 20, 99};
      tbl[5] = '{ 1, 1'b1, 1'b0, 1'b0, 20, 99};

      clr = 1'b0; enable = 1'b0; seal_pulse = 1'b0; op_req = 1'b0; op_qty = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pri", int'(pri_count), 0);
      chk("rst_sec", int'(sec_count), 0);
      chk("rst_estado", int'(estado), 0);
      chk("rst_xfer_busy", int'(xfer_busy), 0);
      chk("rst_load_busy", int'(load_busy), 0);
      chk("rst_op_reject", int'(op_reject), 0);
      chk("rst_ro", int'(ro), 1);
      clr = 1'b1;
      tick();
      seal_n(3);
      chk("seal_empty_pri", int'(pri_count), 0);
      chk("seal_empty_ro", int'(ro), 1);

      enable = 1'b1;
      m_pri = 0; m_sec = 0;
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].do_load) sb.push_back('{1'b1, tbl[i].qty, m_pri, m_sec + tbl[i].qty});
         if (tbl[i].do_xfer) sb.push_back('{1'b0, 20, tbl[i].pri, tbl[i].sec});
         pulse_req(tbl[i].qty);
         chk($sformatf("vec%0d_reject", i), int'(op_reject), int'(tbl[i].rej));
         if (tbl[i].rej) begin
            tick();
            chk($sformatf("vec%0d_reject_width", i), int'(op_reject), 0);
         end
         run_ops(200);
         chk($sformatf("vec%0d_pri", i), int'(pri_count), tbl[i].pri);
         chk($sformatf("vec%0d_sec", i), int'(sec_count), tbl[i].sec);
         m_pri = tbl[i].pri; m_sec = tbl[i].sec;
      end
      chk("ro_after_fill", int'(ro), 0);

      // Transfer takes priority over a pending load, then one IDLE cycle.
      clr = 1'b0;
      tick();
      chk("clr_pri", int'(pri_count), 0);
      chk("clr_sec", int'(sec_count), 0);
      clr = 1'b1;
      sb.push_back('{1'b1, 50, 0, 50});
      sb.push_back('{1'b0, 20, 20, 30});
      pulse_req(50);
      run_ops(200);
      enable = 1'b0;
      seal_n(17);
      chk("prio_setup_pri", int'(pri_count), 3);
      pulse_req(5);
      chk("prio_accept", int'(op_reject), 0);
      tick();
      pulse_req(1);
      chk("reject_while_pending", int'(op_reject), 1);
      tick();
      chk("pending_held_idle", int'(estado), 0);
      sb.push_back('{1'b0, 20, 23, 10});
      sb.push_back('{1'b1, 5, 23, 15});
      enable = 1'b1;
      run_ops(200);

      // Enable gating and seals on transfer cycles 1..3.
      sb.push_back('{1'b1, 20, 23, 35});
      pulse_req(20);
      run_ops(200);
      enable = 1'b0;
      seal_n(19);
      tick(); tick();
      chk("en0_stay_idle", int'(estado), 0);
      chk("en0_pri", int'(pri_count), 4);
      enable = 1'b1;
      tick();
      chk("en1_start_xfer", int'(estado), 1);
      chk("en1_pri_unmoved", int'(pri_count), 4);
      n = 1;
      seal_pulse = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (xfer_busy) n++;
      end
      seal_pulse = 1'b0;
      for (int g = 0; g < 40 && xfer_busy; g++) begin
         tick();
         if (xfer_busy) n++;
      end
      chk("seal_xfer_cycles", n, 20);
      chk("seal_xfer_pri", int'(pri_count), 21);
      chk("seal_xfer_sec", int'(sec_count), 15);

      // Clear asserted during transfer cycle 7.
      sb.push_back('{1'b1, 10, 21, 25});
      pulse_req(10);
      run_ops(200);
      enable = 1'b0;
      seal_n(21);
      chk("pre_clr_ro", int'(ro), 1);
      enable = 1'b1;
      tick();
      chk("pre_clr_xfer", int'(xfer_busy), 1);
      repeat (6) tick();
      chk("pre_clr_pri", int'(pri_count), 6);
      chk("pre_clr_sec", int'(sec_count), 19);
      #2 clr = 1'b0;
      #1;
      chk("mid_clr_pri", int'(pri_count), 0);
      chk("mid_clr_sec", int'(sec_count), 0);
      chk("mid_clr_estado", int'(estado), 0);
      chk("mid_clr_xfer_busy", int'(xfer_busy), 0);
      chk("mid_clr_ro", int'(ro), 1);
      tick(); tick();
      clr = 1'b1;
      repeat (3) tick();
      chk("post_clr_estado", int'(estado), 0);
      chk("post_clr_pri", int'(pri_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
